// File: rtl/fas_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fas_pkg
//  Description : Shared types and constants for the FAS FFT peak analyzer:
//                component width, bin count, complex bin type and the scan
//                state machine encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package fas_pkg;

    localparam int DW    = 16;               // signed 8.8 real/imag width
    localparam int MW    = 2 * DW;           // unsigned magnitude-squared width
    localparam int NBINS = 16;               // bins per frame
    localparam int IW    = $clog2(NBINS);    // bin index width

    // Packed so that re occupies the upper half of the 32-bit bin word.
    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fft_peak_analyzer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fft_peak_analyzer_if
//  Description : Frame input and serial bin / peak result signals of the
//                FFT peak analyzer.
//                master : frame producer / result consumer (drives fft_*)
//                slave  : the analyzer (drives bin_*, freq, done, busy,
//                         overrun)
//  Ports       : fft_valid, fft_d0..fft_d15 ({re,im} per bin),
//                bin_valid, bin_idx, bin_d, bin_mag, freq, done, busy,
//                overrun
//  Revision    : 1.0 - initial release
// ============================================================================
interface fft_peak_analyzer_if;
    import fas_pkg::*;

    logic            fft_valid;
    logic [2*DW-1:0] fft_d0,  fft_d1,  fft_d2,  fft_d3;
    logic [2*DW-1:0] fft_d4,  fft_d5,  fft_d6,  fft_d7;
    logic [2*DW-1:0] fft_d8,  fft_d9,  fft_d10, fft_d11;
    logic [2*DW-1:0] fft_d12, fft_d13, fft_d14, fft_d15;

    logic            bin_valid;
    logic [IW-1:0]   bin_idx;
    logic [2*DW-1:0] bin_d;
    logic [MW-1:0]   bin_mag;
    logic [IW-1:0]   freq;
    logic            done;
    logic            busy;
    logic            overrun;

    modport master (
        output fft_valid,
        output fft_d0,  fft_d1,  fft_d2,  fft_d3,  fft_d4,  fft_d5,  fft_d6,  fft_d7,
        output fft_d8,  fft_d9,  fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
        input  bin_valid, bin_idx, bin_d, bin_mag, freq, done, busy, overrun
    );

    modport slave (
        input  fft_valid,
        input  fft_d0,  fft_d1,  fft_d2,  fft_d3,  fft_d4,  fft_d5,  fft_d6,  fft_d7,
        input  fft_d8,  fft_d9,  fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
        output bin_valid, bin_idx, bin_d, bin_mag, freq, done, busy, overrun
    );

endinterface
`default_nettype wire

// File: rtl/cplx_mag_sq.sv
`default_nettype none
// ============================================================================
//  Module      : cplx_mag_sq
//  Description : Combinational squared magnitude re*re + im*im of a signed
//                complex sample.
//  Ports       : i_re, i_im (signed DW) -> o_mag (unsigned MW)
//  Revision    : 1.0 - initial release
// ============================================================================
module cplx_mag_sq
    import fas_pkg::*;
(
    input  logic signed [DW-1:0] i_re,
    input  logic signed [DW-1:0] i_im,
    output logic        [MW-1:0] o_mag
);

    logic signed [MW-1:0] w_re_x;
    logic signed [MW-1:0] w_im_x;
    logic signed [MW-1:0] w_re_sq;
    logic signed [MW-1:0] w_im_sq;

    // Sign-extend before multiplying so each square is formed at full width.
    assign w_re_x  = MW'(i_re);
    assign w_im_x  = MW'(i_im);
    assign w_re_sq = w_re_x * w_re_x;
    assign w_im_sq = w_im_x * w_im_x;

    // Each square is at most 2^30, so the unsigned sum (max 2^31) cannot wrap.
    assign o_mag = $unsigned(w_re_sq) + $unsigned(w_im_sq);

endmodule
`default_nettype wire

// File: rtl/fft_peak_analyzer.sv
`default_nettype none
// ============================================================================
//  Module      : fft_peak_analyzer
//  Description : Captures 16-bin FFT frames, streams each bin out serially
//                with its squared magnitude and reports the peak bin index.
//                A one-frame pending bank allows a new frame to be accepted
//                while the current one is being scanned.
//  Ports       : clk - rising-edge clock
//                rst - asynchronous, active-low reset
//                bus - fft_peak_analyzer_if.slave (frame in, results out)
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_peak_analyzer
    import fas_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    fft_peak_analyzer_if.slave  bus
);

    localparam logic [IW-1:0] c_LAST_BIN = IW'(NBINS - 1);

    cplx_t         w_in   [NBINS];
    cplx_t         r_act  [NBINS];
    cplx_t         r_pend [NBINS];

    state_t        r_state;
    logic [IW-1:0] r_cnt;
    logic          r_pend_full;
    logic          r_overrun;
    logic [MW-1:0] r_max;
    logic [IW-1:0] r_max_idx;

    logic          r_bin_valid;
    logic [IW-1:0] r_bin_idx;
    cplx_t         r_bin_d;
    logic [MW-1:0] r_bin_mag;
    logic [IW-1:0] r_freq;
    logic          r_done;

    cplx_t         w_sel;
    logic [MW-1:0] w_mag;
    logic          w_cap_act;
    logic          w_cap_pend;
    logic          w_drop;
    logic          w_copy;
    logic          w_new_max;

    assign w_in[0]  = bus.fft_d0;
    assign w_in[1]  = bus.fft_d1;
    assign w_in[2]  = bus.fft_d2;
    assign w_in[3]  = bus.fft_d3;
    assign w_in[4]  = bus.fft_d4;
    assign w_in[5]  = bus.fft_d5;
    assign w_in[6]  = bus.fft_d6;
    assign w_in[7]  = bus.fft_d7;
    assign w_in[8]  = bus.fft_d8;
    assign w_in[9]  = bus.fft_d9;
    assign w_in[10] = bus.fft_d10;
    assign w_in[11] = bus.fft_d11;
    assign w_in[12] = bus.fft_d12;
    assign w_in[13] = bus.fft_d13;
    assign w_in[14] = bus.fft_d14;
    assign w_in[15] = bus.fft_d15;

    // A frame goes straight to the active bank when nothing is scanning, or
    // in FIN when no pending frame is waiting to take over.  Any frame that
    // arrives while the pending bank is occupied is dropped.
    assign w_cap_act  = bus.fft_valid && ((r_state == IDLE) ||
                                          ((r_state == FIN) && !r_pend_full));
    assign w_cap_pend = bus.fft_valid && (r_state == SCAN) && !r_pend_full;
    assign w_drop     = bus.fft_valid && r_pend_full;
    assign w_copy     = (r_state == FIN) && r_pend_full;

    assign w_sel = r_act[r_cnt];

    cplx_mag_sq u_mag (
        .i_re  (w_sel.re),
        .i_im  (w_sel.im),
        .o_mag (w_mag)
    );

    // Bin 0 seeds the running max; later bins need a strictly larger value,
    // so the lowest index wins a tie.
    assign w_new_max = (r_cnt == '0) || (w_mag > r_max);

    // Frame storage carries no reset: contents are only read after a capture.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NBINS; k++) begin
            if (w_cap_act) begin
                r_act[k] <= w_in[k];
            end else if (w_copy) begin
                r_act[k] <= r_pend[k];
            end
            if (w_cap_pend) begin
                r_pend[k] <= w_in[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_pend_full <= 1'b0;
            r_overrun   <= 1'b0;
            r_max       <= '0;
            r_max_idx   <= '0;
            r_bin_valid <= 1'b0;
            r_bin_idx   <= '0;
            r_bin_d     <= '0;
            r_bin_mag   <= '0;
            r_freq      <= '0;
            r_done      <= 1'b0;
        end else begin
            r_bin_valid <= 1'b0;
            r_done      <= 1'b0;

            if (w_drop) begin
                r_overrun <= 1'b1;
            end
            if (w_cap_pend) begin
                r_pend_full <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_cap_act) begin
                        r_state <= SCAN;
                        r_cnt   <= '0;
                    end
                end

                SCAN: begin
                    r_bin_valid <= 1'b1;
                    r_bin_idx   <= r_cnt;
                    r_bin_d     <= w_sel;
                    r_bin_mag   <= w_mag;
                    if (w_new_max) begin
                        r_max     <= w_mag;
                        r_max_idx <= r_cnt;
                    end
                    // Last bin: the peak decision includes this bin's magnitude.
                    if (r_cnt == c_LAST_BIN) begin
                        r_done  <= 1'b1;
                        r_freq  <= w_new_max ? r_cnt : r_max_idx;
                        r_state <= FIN;
                    end
                    r_cnt <= r_cnt + 1'b1;
                end

                FIN: begin
                    if (r_pend_full) begin
                        r_pend_full <= 1'b0;
                        r_state     <= SCAN;
                        r_cnt       <= '0;
                    end else if (w_cap_act) begin
                        r_state <= SCAN;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.bin_valid = r_bin_valid;
    assign bus.bin_idx   = r_bin_idx;
    assign bus.bin_d     = r_bin_d;
    assign bus.bin_mag   = r_bin_mag;
    assign bus.freq      = r_freq;
    assign bus.done      = r_done;
    assign bus.busy      = (r_state == SCAN) || r_pend_full;
    assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fft_peak_analyzer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_fft_peak_analyzer
//  Description : Self-checking bench for fft_peak_analyzer. A frame-level
//                reference model schedules accepted frames, drops and peaks
//                and predicts every output on every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_peak_analyzer;
    import fas_pkg::*;

    localparam int MAXF = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    fft_peak_analyzer_if bus ();

    fft_peak_analyzer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks    = 0;
    int          errors    = 0;
    int          cyc       = 0;
    logic [31:0] fr [MAXF][16];
    int          f_start [MAXF];
    int          f_capt  [MAXF];
    int          f_peak  [MAXF];
    int          nf        = 0;
    int          first     = 0;
    int          drop_edge = -1;
    logic [31:0] frame [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at edge %0d: observed 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] mag_of(input logic [31:0] d);
        longint re, im;
        re = longint'($signed(d[31:16]));
        im = longint'($signed(d[15:0]));
        return 32'(re * re + im * im);
    endfunction

    // First index holding the largest magnitude.
    function automatic int peak_of();
        longint best;
        int     idx;
        best = -1;
        idx  = 0;
        for (int k = 0; k < 16; k++) begin
            if (longint'(mag_of(frame[k])) > best) begin
                best = longint'(mag_of(frame[k]));
                idx  = k;
            end
        end
        return idx;
    endfunction

    // Frame arriving at edge t: scanning takes edges s+1..s+16 and FIN is at
    // s+17; a frame accepted during a scan starts at that FIN edge; a frame
    // arriving while another is already waiting is lost.
    task automatic arrive(input int t);
        int l, s;
        s = t;
        if (nf > first) begin
            l = nf - 1;
            if (f_capt[l] < f_start[l] && t <= f_start[l]) begin
                if (drop_edge < 0) drop_edge = t;
                return;
            end else if (t >= f_start[l] + 17) begin
                s = t;
            end else begin
                s = f_start[l] + 17;
            end
        end
        if (nf >= MAXF) begin
            $display("FAIL model_capacity: observed %0d frames, limit %0d", nf, MAXF);
            $fatal(1, "frame table exhausted");
        end
        for (int k = 0; k < 16; k++) fr[nf][k] = frame[k];
        f_start[nf] = s;
        f_capt[nf]  = t;
        f_peak[nf]  = peak_of();
        nf++;
    endtask

    task automatic check_cycle(input int e);
        logic        ev, edn, eb, eov;
        logic [3:0]  eidx, efr;
        logic [31:0] ed;
        ev = 1'b0; edn = 1'b0; eb = 1'b0; eidx = '0; efr = '0; ed = '0;
        for (int f = first; f < nf; f++) begin
            int s;
            s = f_start[f];
            if (e >= s + 1 && e <= s + 16) begin
                ev   = 1'b1;
                eidx = 4'(e - s - 1);
                ed   = fr[f][e - s - 1];
            end
            if (e == s + 16) edn = 1'b1;
            if (e >= s + 16) efr = 4'(f_peak[f]);
            if ((e >= s && e <= s + 15) || (f_capt[f] <= e && e < s)) eb = 1'b1;
        end
        eov = (drop_edge >= 0) && (e >= drop_edge);
        chk("bin_valid", 32'(bus.bin_valid), 32'(ev));
        if (ev) begin
            chk("bin_idx", 32'(bus.bin_idx), 32'(eidx));
            chk("bin_d",   bus.bin_d,        ed);
            chk("bin_mag", bus.bin_mag,      mag_of(ed));
        end
        chk("done",    32'(bus.done),    32'(edn));
        chk("freq",    32'(bus.freq),    32'(efr));
        chk("busy",    32'(bus.busy),    32'(eb));
        chk("overrun", 32'(bus.overrun), 32'(eov));
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        check_cycle(cyc);
    endtask

    task automatic drive_data();
        bus.fft_d0  = frame[0];  bus.fft_d1  = frame[1];  bus.fft_d2  = frame[2];  bus.fft_d3  = frame[3];
        bus.fft_d4  = frame[4];  bus.fft_d5  = frame[5];  bus.fft_d6  = frame[6];  bus.fft_d7  = frame[7];
        bus.fft_d8  = frame[8];  bus.fft_d9  = frame[9];  bus.fft_d10 = frame[10]; bus.fft_d11 = frame[11];
        bus.fft_d12 = frame[12]; bus.fft_d13 = frame[13]; bus.fft_d14 = frame[14]; bus.fft_d15 = frame[15];
    endtask

    task automatic send();
        drive_data();
        bus.fft_valid = 1'b1;
        arrive(cyc + 1);
        step();
        bus.fft_valid = 1'b0;
    endtask

    task automatic clear_frame();
        for (int k = 0; k < 16; k++) frame[k] = 32'h0;
    endtask

    task automatic rand_frame();
        int mode, a, b;
        mode = int'($urandom_range(0, 2));
        for (int k = 0; k < 16; k++) begin
            a = int'($urandom_range(0, 6)) - 3;
            b = int'($urandom_range(0, 6)) - 3;
            case (mode)
                0:       frame[k] = $urandom;
                1:       frame[k] = ($urandom_range(0, 3) == 0) ? 32'h0100_0000 : 32'h0;
                default: frame[k] = {16'(a), 16'(b)};
            endcase
        end
    endtask

    initial begin
        bus.fft_valid = 1'b0;
        clear_frame();
        drive_data();

        // Reset state.
        #1;
        chk("rst_bin_valid", 32'(bus.bin_valid), 32'h0);
        chk("rst_done",      32'(bus.done),      32'h0);
        chk("rst_freq",      32'(bus.freq),      32'h0);
        chk("rst_busy",      32'(bus.busy),      32'h0);
        chk("rst_overrun",   32'(bus.overrun),   32'h0);
        repeat (3) step();
        rst = 1'b1;
        repeat (2) step();

        // Single peak at bin 5: 3.0 + j4.0 -> 25.0.
        clear_frame();
        frame[5] = {16'h0300, 16'h0400};
        send();
        repeat (6) step();
        chk("bin5_idx", 32'(bus.bin_idx), 32'd5);
        chk("bin5_mag", bus.bin_mag, 32'h0019_0000);
        repeat (10) step();
        chk("peak5_done", 32'(bus.done), 32'h1);
        chk("peak5_freq", 32'(bus.freq), 32'd5);
        step();
        chk("peak5_done_end", 32'(bus.done), 32'h0);
        repeat (3) step();

        // Tie between bins 3 and 9: lower index wins.
        clear_frame();
        frame[3] = 32'h0100_0000;
        frame[9] = 32'h0100_0000;
        send();
        repeat (16) step();
        chk("tie_freq", 32'(bus.freq), 32'd3);
        repeat (3) step();

        // Most negative components: magnitude 2^31 without wrap.
        clear_frame();
        frame[12] = 32'h8000_8000;
        send();
        repeat (13) step();
        chk("neg_mag", bus.bin_mag, 32'h8000_0000);
        repeat (3) step();
        chk("neg_freq", 32'(bus.freq), 32'd12);
        repeat (3) step();

        // Back-to-back frames 16 cycles apart, peaks at 2 then 14.
        rand_frame();
        for (int k = 0; k < 16; k++) frame[k] = {8'h0, frame[k][23:16], 8'h0, frame[k][7:0]};
        frame[2] = 32'h4000_4000;
        send();
        repeat (15) step();
        rand_frame();
        for (int k = 0; k < 16; k++) frame[k] = {8'h0, frame[k][23:16], 8'h0, frame[k][7:0]};
        frame[14] = 32'h4000_4000;
        send();
        chk("b2b_freq_a", 32'(bus.freq), 32'd2);
        repeat (17) step();
        chk("b2b_freq_b", 32'(bus.freq), 32'd14);
        chk("b2b_overrun", 32'(bus.overrun), 32'h0);
        repeat (4) step();

        // Three frames one cycle apart: the third is dropped.
        repeat (3) begin
            rand_frame();
            send();
        end
        repeat (40) step();
        chk("ovr_sticky", 32'(bus.overrun), 32'h1);

        // Reset while bin 7 is on the output.
        rand_frame();
        send();
        repeat (8) step();
        chk("mid_bin_idx", 32'(bus.bin_idx), 32'd7);
        rst = 1'b0;
        #1;
        chk("mid_bin_valid", 32'(bus.bin_valid), 32'h0);
        chk("mid_bin_idx0",  32'(bus.bin_idx),   32'h0);
        chk("mid_bin_d",     bus.bin_d,          32'h0);
        chk("mid_bin_mag",   bus.bin_mag,        32'h0);
        chk("mid_freq",      32'(bus.freq),      32'h0);
        chk("mid_busy",      32'(bus.busy),      32'h0);
        chk("mid_overrun",   32'(bus.overrun),   32'h0);
        first     = nf;
        drop_edge = -1;
        repeat (3) step();
        rst = 1'b1;
        repeat (2) step();
        rand_frame();
        send();
        repeat (20) step();

        // Random frames with random spacing.
        for (int n = 0; n < 24; n++) begin
            rand_frame();
            send();
            repeat ($urandom_range(0, 24)) step();
        end
        repeat (40) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_peak_analyzer.md
Name: fft_peak_analyzer

Overview:
- Consumer of the FAS FFT result interface.
- Takes one 16-bin frame per fft_valid pulse, on fft_d0..fft_d15, each {real[31:16], imag[15:0]}, signed 8.8.
- Streams the bins out serially with a squared magnitude for each bin.
- Reports the index of the peak bin on freq, qualified by a one-cycle done pulse.
- A one-frame pending buffer lets frames arrive back-to-back every 16 cycles.

Parameters:
- DW, 16, width of each real/imag component (signed).
- MW, 2*DW, magnitude-squared width (unsigned); 2*(2^(DW-1))^2 = 2^31 fits in 32 bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- fft_valid  in  1  one-cycle strobe; fft_d0..fft_d15 are valid in that cycle
- fft_d0..fft_d15  in  32 each  bin k = {re, im}, signed DW each
- bin_valid  out  1  serial bin output is valid
- bin_idx  out  4  index of the bin being output
- bin_d  out  32  captured {re, im} of the bin
- bin_mag  out  MW  re*re + im*im, unsigned
- freq  out  4  peak bin index of the last completed frame
- done  out  1  one-cycle pulse; freq is updated in the same cycle
- busy  out  1  high in SCAN or while the pending buffer is full
- overrun  out  1  sticky; a frame was dropped

Behaviour:
- Reset (rst low, asynchronous): all outputs go to 0. State goes to IDLE, pending buffer is empty, running max is 0.
- Storage: active bank, 16x32, and pending bank, 16x32.
- Capture: when fft_valid is high at a rising edge:
  - IDLE: write into the active bank and go to SCAN.
  - SCAN with pending empty: write into the pending bank and set pend_full.
  - SCAN with pend_full: drop the frame, set overrun, leave both banks untouched.
- State machine:
  - IDLE -> SCAN on capture.
  - SCAN holds a 4-bit counter cnt from 0 to 15.
  - At cnt==15, SCAN -> FIN.
  - FIN lasts one cycle. It copies pending into active if pend_full (clearing pend_full) and goes to SCAN; otherwise it goes to IDLE.
  - Also in FIN: if fft_valid is high in the same cycle and pend_full is clear, the new frame goes directly to the active bank and the next state is SCAN.
- Serial output is registered:
  - Bin k appears with bin_valid=1 in the cycle after the edge where cnt==k is processed.
  - For capture at edge T, bin 0 is at cycle T+2 and bin 15 is at cycle T+17.
- Magnitude: signed DW x DW products are sign-extended to MW, then added; no saturation is needed.
- Peak tracking:
  - At cnt==0, max is loaded unconditionally with bin 0.
  - After that, max is replaced only when mag > max (strict), so the lowest index wins a tie.
- Completion:
  - done=1 for exactly one cycle, the cycle in which bin 15 is output (T+17).
  - freq is loaded in that same cycle and held until the next done.
- Timing and side effects:
  - Steady-state throughput is one frame per 17 cycles (16 SCAN + 1 FIN).
  - Frames arriving every 16 cycles eventually overrun. This is accepted; the sticky overrun flag reports it.
  - overrun clears only on reset.
  - Reset mid-SCAN abandons the frame with no done pulse.

Decomposition:
- Package fas_pkg holds:
  - DW and NBINS=16
  - typedef cplx_t {logic signed [DW-1:0] re, im}
  - the state enum {IDLE, SCAN, FIN}
- Sub-module cplx_mag_sq: combinational re^2 + im^2, widths set by DW/MW, instantiated once on the selected active bin.

Test Plan:
- Reset then one frame with bin 5 = {0x0300, 0x0400} and all others 0:
  - bin_mag at idx 5 is 0x00190000 (25.0 in 16.16).
  - freq=5 and done pulse at T+17, single cycle.
- Tie: bins 3 and 9 both {0x0100, 0} and all others 0 -> freq=3.
- Negative extremes: bin 12 = {0x8000, 0x8000} -> bin_mag = 0x80000000, freq=12, no wrap.
- Back-to-back, frame A peak at 2 and frame B peak at 14, fft_valid 16 cycles apart:
  - Two done pulses 17 cycles apart, with freq 2 then 14.
  - B's bins follow A's bin 15 after the one-cycle FIN gap.
  - overrun stays 0.
- Three frames 1 cycle apart: frames 1 and 2 are processed, frame 3 is dropped, overrun=1 and stays set.
- Assert rst low at the cnt==7 output:
  - All outputs go to 0 immediately and no done pulse occurs.
  - A new frame after release gives the correct freq.
